// File: rtl/seg7_reader.sv
// Recovers the hex value shown on a multiplexed 7-segment display and publishes
// it under valid/ready once the same frame has been seen for STABLE_SCANS scans.
module seg7_reader #(
  parameter int NDIGITS      = 4,
  parameter int STABLE_SCANS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NDIGITS-1:0]     digit,
  input  logic [7:0]             leds,
  input  logic                   ready,
  output logic [4*NDIGITS-1:0]   value,
  output logic [NDIGITS-1:0]     dp,
  output logic [NDIGITS-1:0]     err,
  output logic                   valid,
  output logic                   overrun
);

  localparam int CW = $clog2(STABLE_SCANS + 1);
  localparam int FW = 6 * NDIGITS;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_SCANS);

  // Handshake: valid stays high with stable data until an edge where
  // valid && ready; a publish on that same edge keeps valid high with new data.
  // A publish while valid && !ready overwrites the data and sets sticky overrun.

  logic [4*NDIGITS-1:0] shadow_val, cand_val;
  logic [NDIGITS-1:0]   shadow_dp, shadow_err, cand_dp, cand_err, seen;
  logic [FW-1:0]        last_frame;
  logic                 last_valid;
  logic [CW-1:0]        match_cnt, next_cnt;
  logic [4:0]           dec;
  logic                 one_hot, scan_done, same, publish;

  // Returns {err, nibble}; unknown glyphs decode to 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F: decode = 5'h00;
      7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;
      7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;
      7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;
      7'h07: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;
      7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;
      7'h71: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    one_hot  = (digit != '0) && ((digit & (digit - NDIGITS'(1))) == '0);
    dec      = decode(leds[6:0]);
    cand_val = shadow_val;
    cand_dp  = shadow_dp;
    cand_err = shadow_err;
    for (int i = 0; i < NDIGITS; i++) begin
      if (digit[i]) begin
        cand_val[4*i +: 4] = dec[3:0];
        cand_dp[i]         = leds[7];
        cand_err[i]        = dec[4];
      end
    end
    scan_done = one_hot && ((seen | digit) == '1);
    same      = last_valid && ({cand_val, cand_dp, cand_err} == last_frame);
    if (!same)                  next_cnt = CW'(1);
    else if (match_cnt == CNT_MAX) next_cnt = match_cnt;
    else                        next_cnt = match_cnt + CW'(1);
    // The !same term lets STABLE_SCANS = 1 publish every changed frame.
    publish = scan_done && (next_cnt == CNT_MAX) && ((match_cnt != CNT_MAX) || !same);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      shadow_err <= '0;
      seen       <= '0;
      last_frame <= '0;
      last_valid <= 1'b0;
      match_cnt  <= '0;
      value      <= '0;
      dp         <= '0;
      err        <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (one_hot) begin
        shadow_val <= cand_val;
        shadow_dp  <= cand_dp;
        shadow_err <= cand_err;
        seen       <= scan_done ? '0 : (seen | digit);
      end
      if (scan_done) begin
        match_cnt  <= next_cnt;
        last_frame <= {cand_val, cand_dp, cand_err};
        last_valid <= 1'b1;
      end
      if (publish) begin
        value <= cand_val;
        dp    <= cand_dp;
        err   <= cand_err;
        valid <= 1'b1;
        if (valid && !ready) overrun <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: drives display scans, queues expected publishes and
// compares them when the reader presents a new frame.
module tb_seg7_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  digit = '0;
  logic [7:0]  leds = '0;
  logic        ready = 1'b0;
  logic [15:0] value;
  logic [3:0]  dp, err;
  logic        valid, overrun;

  int n_checks = 0;
  int n_fail = 0;
  int n_pushed = 0;
  int n_seen = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_exp;
  logic        prev_valid = 1'b0;
  logic [23:0] prev_data = '0;

  always #5 clk = ~clk;

  seg7_reader #(.NDIGITS(4), .STABLE_SCANS(2)) dut (
    .clk(clk), .reset(reset), .digit(digit), .leds(leds), .ready(ready),
    .value(value), .dp(dp), .err(err), .valid(valid), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'h3F;  4'h1: glyph = 8'h06;  4'h2: glyph = 8'h5B;  4'h3: glyph = 8'h4F;
      4'h4: glyph = 8'h66;  4'h5: glyph = 8'h6D;  4'h6: glyph = 8'h7D;  4'h7: glyph = 8'h07;
      4'h8: glyph = 8'h7F;  4'h9: glyph = 8'h6F;  4'hA: glyph = 8'h77;  4'hB: glyph = 8'h7C;
      4'hC: glyph = 8'h39;  4'hD: glyph = 8'h5E;  4'hE: glyph = 8'h79;  default: glyph = 8'h71;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle(input logic [3:0] d, input logic [7:0] l);
    digit = d;
    leds  = l;
    tick();
    digit = '0;
  endtask

  task automatic sample(input int i, input logic [7:0] l);
    drive_cycle(4'(1 << i), l);
  endtask

  task automatic scan_raw(input logic [7:0] l3, l2, l1, l0);
    sample(3, l3);
    sample(2, l2);
    sample(1, l1);
    sample(0, l0);
  endtask

  task automatic show(input logic [15:0] h);
    scan_raw(glyph(h[15:12]), glyph(h[11:8]), glyph(h[7:4]), glyph(h[3:0]));
  endtask

  // Same scan, with blank and ghosted cycles carrying a full "8" in between.
  task automatic show_noisy(input logic [15:0] h);
    sample(3, glyph(h[15:12]));
    drive_cycle(4'b0000, 8'h7F);
    sample(2, glyph(h[11:8]));
    drive_cycle(4'b0110, 8'h7F);
    sample(1, glyph(h[7:4]));
    drive_cycle(4'b0110, 8'h7F);
    drive_cycle(4'b0000, 8'h7F);
    drive_cycle(4'b0110, 8'hFF);
    sample(0, glyph(h[3:0]));
  endtask

  task automatic expect_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    exp_q.push_back({v, d, e});
    n_pushed++;
  endtask

  task automatic accept();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_value"}, 32'(value), 32'h0);
    check({tag, "_dp"}, 32'(dp), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_valid"}, 32'(valid), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
  endtask

  // Scoreboard: a publish is valid rising or the frame changing while valid.
  always @(negedge clk) begin
    if (!reset && valid && (!prev_valid || {value, dp, err} != prev_data)) begin
      n_seen++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("publish_frame", 32'({value, dp, err}), 32'(mon_exp));
      end
    end
    prev_valid = valid;
    prev_data  = {value, dp, err};
  end

  initial begin
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Stable "1234"
    show(16'h1234);
    check("1234_scan1_valid", 32'(valid), 32'h0);
    expect_frame(16'h1234, 4'h0, 4'h0);
    show(16'h1234);
    check("1234_valid", 32'(valid), 32'h1);
    check("1234_value", 32'(value), 32'h1234);
    show(16'h1234);
    accept();
    check("1234_accept_valid", 32'(valid), 32'h0);
    show(16'h1234);
    check("1234_held_no_republish", 32'(valid), 32'h0);

    // Value change with a mismatched intermediate scan
    show(16'hABCD);
    show(16'h1234);
    show(16'hABCD);
    check("abcd_rearm_valid", 32'(valid), 32'h0);
    expect_frame(16'hABCD, 4'h0, 4'h0);
    show(16'hABCD);
    check("abcd_value", 32'(value), 32'hABCD);
    accept();

    // Illegal glyphs: digit 2 blank, digit 0 dp only
    expect_frame(16'h1010, 4'b0001, 4'b0101);
    scan_raw(8'h06, 8'h00, 8'h06, 8'h80);
    scan_raw(8'h06, 8'h00, 8'h06, 8'h80);
    check("illegal_err", 32'(err), 32'h5);
    check("illegal_dp", 32'(dp), 32'h1);
    accept();

    // Blanking and ghosting
    show_noisy(16'h4321);
    check("noisy_scan1_valid", 32'(valid), 32'h0);
    expect_frame(16'h4321, 4'h0, 4'h0);
    show_noisy(16'h4321);
    check("noisy_value", 32'(value), 32'h4321);
    accept();

    // Overrun
    expect_frame(16'h1111, 4'h0, 4'h0);
    show(16'h1111);
    show(16'h1111);
    check("pre_overrun", 32'(overrun), 32'h0);
    expect_frame(16'h2222, 4'h0, 4'h0);
    show(16'h2222);
    show(16'h2222);
    check("overrun_value", 32'(value), 32'h2222);
    check("overrun_valid", 32'(valid), 32'h1);
    check("overrun_set", 32'(overrun), 32'h1);
    accept();
    check("overrun_accept_valid", 32'(valid), 32'h0);
    check("overrun_sticky", 32'(overrun), 32'h1);

    // Reset mid-scan
    sample(0, glyph(4'h8));
    sample(1, glyph(4'h7));
    reset = 1'b1;
    tick();
    check_all_zero("midreset");
    tick();
    reset = 1'b0;
    check_all_zero("postreset");
    show(16'h5678);
    check("5678_scan1_valid", 32'(valid), 32'h0);
    expect_frame(16'h5678, 4'h0, 4'h0);
    show(16'h5678);
    check("5678_value", 32'(value), 32'h5678);
    check("5678_valid", 32'(valid), 32'h1);

    repeat (4) tick();
    check("publish_count", 32'(n_seen), 32'(n_pushed));
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Recovers the hexadecimal value shown on a multiplexed 7-segment display by sampling the digit-enable and segment lines and inverting the standard hex segment map. It turns a driven display back into a 4-bit-per-digit value, with a decimal-point mask and per-digit error flags. It sits on the display bus beside the display driver: as a self-check monitor in hardware, or as the receive end when a display bus is used as a link. Results are published only after the display holds the same frame for a programmable number of full scans, and are held under a valid/ready handshake.

## Interface
- NDIGITS, 4: number of multiplexed digits.
- STABLE_SCANS, 2: consecutive identical complete scans required before publishing; must be ≥1.

- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- digit  input  NDIGITS  digit enables, active-high, expected one-hot; bit i selects digit i.
- leds  input  8  segment cathodes, active-high; bit0 = a … bit6 = g, bit7 = dp.
- ready  input  1  consumer accepts the published frame.
- value  output  4*NDIGITS  decoded nibbles; digit i maps to value[4i+3:4i].
- dp  output  NDIGITS  leds[7] captured per digit.
- err  output  NDIGITS  per-digit flag: the captured pattern was not a legal hex glyph.
- valid  output  1  published frame available.
- overrun  output  1  sticky: a publish replaced a frame that was never accepted.

## Operation
- Inverse map for leds[6:0] to nibble: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - Any other pattern, including blank 00, gives nibble 0 with the digit's err bit set.
- Sample cycle: a cycle in which digit has exactly one bit set.
  - Digit pattern all-zero or multi-hot: ignored (blanking/ghosting). No state change.
- Each sample writes {nibble, dp, err} into the shadow slot for that digit and sets seen[i].
  - Repeat samples of the same digit before the scan completes overwrite the slot; the last sample wins.
- Scan complete: the sample that makes seen all-ones.
  - The candidate frame is the shadow slots merged with that sample.
  - seen clears on the same edge.
- On scan complete:
  - Candidate equals last_frame (all nibble, dp and err bits) and last_valid = 1: match_cnt increments, saturating at STABLE_SCANS.
  - Otherwise: match_cnt = 1.
  - last_frame takes the candidate and last_valid is set.
- Publish: on the scan-complete edge where the new match_cnt equals STABLE_SCANS and the old match_cnt did not.
  - A held display therefore publishes once. A change re-arms publishing.
  - With STABLE_SCANS = 1, every scan whose candidate differs from last_frame publishes. The first scan after reset also publishes.
- Publish action: value, dp and err load the candidate, and valid is set.
- Handshake:
  - valid && ready at an edge: valid clears, unless a publish occurs on that same edge, in which case valid stays 1 with the new data.
  - Publish while valid && !ready: outputs are overwritten, valid stays 1, and overrun is set.
  - overrun clears only on reset.
- Reset:
  - value, dp, err, valid and overrun are all 0.
  - seen, shadow, match_cnt and last_valid are cleared.
  - Reset mid-scan discards the partial scan. The next scan starts from an empty seen mask.

## Timing
- Sampling registers leds and digit directly. There is no input synchronizer; the source shares clk.
- Latency: valid and data update on the rising edge that ends the scan-completing sample cycle. They are visible the next cycle.
- A single-cycle dwell per digit is sufficient. The minimum scan is NDIGITS sample cycles.
- ready is sampled at the edge only. There is no combinational path from ready to any output.
- Outputs are stable while valid = 1 and no publish occurs.
- Reset has priority over all other events on the same edge.

## Test plan
- Stable "1234": drive digit 3..0 showing 06, 5B, 4F, 66, cycled twice, ready = 0.
  - value = 16'h1234, err = 0, dp = 0.
  - valid rises one cycle after the last sample of scan 2. There is no second publish on scan 3.
- Value change: after "1234" is accepted, display "AbCd" (77, 7C, 39, 5E) for 2 scans.
  - A single publish with value = 16'hABCD.
  - A mismatched intermediate scan resets match_cnt to 1.
- Illegal glyph: digit 2 shows 00 and digit 0 shows 80 (dp only) for 2 scans.
  - err = 4'b0101, dp = 4'b0001, and those nibbles are 0.
- Blanking and ghosting: digit = 0000 and 0110 cycles are interleaved with leds = 7F.
  - The shadow is unchanged and no scan completes from those cycles.
- Overrun: ready = 0, "1111" is published, then "2222" is held for 2 scans.
  - value = 16'h2222, valid = 1, overrun = 1.
  - ready pulsed for one cycle drops valid, and overrun stays 1.
- Reset mid-scan: reset after digits 0 and 1 are sampled, then a full "5678" for 2 scans.
  - All outputs are 0 during and after reset.
  - The first publish occurs only after two complete post-reset scans, with value = 16'h5678.
